alu_iterative: RTL

Iterative execute-stage ALU that consumes the 4-bit `ALU_control` code produced by the ALU control decoder and returns a registered result plus zero flag through a start/done handshake. Logic, arithmetic and compare operations finish in one cycle. Shifts run on a serial one-bit-per-cycle shifter, which saves barrel-shifter area. The block sits between the register-file/immediate operand muxes and the writeback/branch logic. The controller stalls on `busy`.

---
 rtl/alu_iterative.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_iterative.sv
// Execute-stage ALU with start/done handshake: logic, arithmetic and compares finish
// in one cycle, shifts run on a serial one-bit-per-cycle shifter.
module alu_iterative #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic [3:0]         ALU_control,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               busy,
  output logic               done
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  typedef enum logic [1:0] {
    SH_LL,
    SH_RL,
    SH_RA
  } shift_t;

  state_t             state_q,  state_d;
  shift_t             shift_q,  shift_d;
  logic [WIDTH-1:0]   work_q,   work_d;
  logic [SHAMT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q,   zero_d;
  logic               done_q,   done_d;

  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   work_step;
  logic               is_shift;
  shift_t             shift_kind;

  // Single-cycle datapath; shift codes never reach the result mux from here.
  always_comb begin
    alu_res = '0;
    case (ALU_control)
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    is_shift   = 1'b0;
    shift_kind = SH_LL;
    case (ALU_control)
      OP_SLL: begin is_shift = 1'b1; shift_kind = SH_LL; end
      OP_SRL: begin is_shift = 1'b1; shift_kind = SH_RL; end
      OP_SRA: begin is_shift = 1'b1; shift_kind = SH_RA; end
      default: begin is_shift = 1'b0; shift_kind = SH_LL; end
    endcase
  end

  // One bit of shift per cycle in the direction latched at start.
  always_comb begin
    work_step = work_q;
    case (shift_q)
      SH_LL:   work_step = {work_q[WIDTH-2:0], 1'b0};
      SH_RL:   work_step = {1'b0, work_q[WIDTH-1:1]};
      SH_RA:   work_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: work_step = work_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_shift) begin
            work_d  = A;
            cnt_d   = B[SHAMT_W-1:0];
            shift_d = shift_kind;
            state_d = ST_SHIFT;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        // Requests arriving here are dropped, not queued.
        if (cnt_q == '0) begin
          result_d = work_q;
          zero_d   = (work_q == '0);
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          work_d = work_step;
          cnt_d  = cnt_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      shift_q  <= SH_LL;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign done   = done_q;
  assign busy   = (state_q == ST_SHIFT);

endmodule
